instr_seq: RTL and testbench

Instruction sequencer that sits directly upstream of the `dsp` core and drives its `opcode`, `mem_addr` and `imm_val` inputs. It holds a small loadable program buffer. On a start pulse it issues one instruction per clock, runs the program a programmable number of passes, then signals completion. While not running it drives a no-op instruction, so the downstream datapath stays quiescent.

---
 rtl/instr_seq_pkg.sv | 30 +++
 rtl/instr_seq_if.sv | 49 ++++
 rtl/instr_seq_prog_buf.sv | 25 ++
 rtl/instr_seq.sv | 106 ++++++++++
 tb/tb_instr_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_seq_pkg;

    // Instruction word layout: {opcode, mem_addr, imm_val}
    localparam int INSTR_W = 11;
    localparam int OP_W    = 3;
    localparam int OP_LSB  = 8;
    localparam int MA_W    = 4;
    localparam int MA_LSB  = 4;
    localparam int IMM_W   = 4;
    localparam int IMM_LSB = 0;

    // Opcode that leaves the downstream dsp datapath idle
    localparam logic [OP_W-1:0] NOP_OP_DEF = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [MA_W-1:0]  mem_addr;
        logic [IMM_W-1:0] imm_val;
    } instr_t;

endpackage

// File: rtl/instr_seq_if.sv
// Control, program-load and dsp-facing instruction bundle of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the dsp side always accepts, step/abort throttle issue.
// Step ports exist only when INSTR_SEQ_STEP_EN is defined.
interface instr_seq_if
    import instr_seq_pkg::*;
#(
    parameter int AW = 4
) ();
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [AW-1:0]      prog_last;
    logic [3:0]         rep_cnt;
    logic               start;
    logic               abort;
`ifdef INSTR_SEQ_STEP_EN
    logic               step_mode;
    logic               step;
`endif
    logic [OP_W-1:0]    opcode;
    logic [MA_W-1:0]    mem_addr;
    logic [IMM_W-1:0]   imm_val;
    logic               issue;
    logic               busy;
    logic               done;

`ifdef INSTR_SEQ_STEP_EN
    modport master (
        output prog_we, prog_addr, prog_data, prog_last, rep_cnt, start, abort,
               step_mode, step,
        input  opcode, mem_addr, imm_val, issue, busy, done
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, prog_last, rep_cnt, start, abort,
               step_mode, step,
        output opcode, mem_addr, imm_val, issue, busy, done
    );
`else
    modport master (
        output prog_we, prog_addr, prog_data, prog_last, rep_cnt, start, abort,
        input  opcode, mem_addr, imm_val, issue, busy, done
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, prog_last, rep_cnt, start, abort,
        output opcode, mem_addr, imm_val, issue, busy, done
    );
`endif
endinterface

// File: rtl/instr_seq_prog_buf.sv
// Program buffer: DEPTH x INSTR_W register file, no reset.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller gates writes.
module prog_buf
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    // Synchronous write port; contents survive reset by design
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer feeding the dsp core: runs a loaded program for N passes.
// Latency: start at edge E -> buf[0] on outputs after E+1; done one cycle after last issue.
// Backpressure: none from dsp; abort stops at the next edge, step mode (INSTR_SEQ_STEP_EN) gates issue.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int              DEPTH  = 16,
    parameter int              AW     = 4,
    parameter logic [OP_W-1:0] NOP_OP = NOP_OP_DEF
) (
    input  logic     clk,
    input  logic     rst,
    instr_seq_if.slave sif
);
    state_t          state;
    logic [AW-1:0]   pc;
    logic [3:0]      pass;
    logic [AW-1:0]   last_q;
    logic [3:0]      rep_q;
    logic [INSTR_W-1:0] rd_word;
    instr_t          cur;
    logic            advance;
    logic            buf_we;

    // The buffer only changes while idle so a running program is never disturbed
    assign buf_we = sif.prog_we && (state == S_IDLE);

    prog_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (sif.prog_addr),
        .wdata (sif.prog_data),
        .raddr (pc),
        .rdata (rd_word)
    );

    assign cur = instr_t'(rd_word);

`ifdef INSTR_SEQ_STEP_EN
    assign advance = !sif.step_mode || sif.step;
`else
    assign advance = 1'b1;
`endif

    // Sequencer FSM with registered dsp-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            pass         <= '0;
            last_q       <= '0;
            rep_q        <= '0;
            sif.opcode   <= NOP_OP;
            sif.mem_addr <= '0;
            sif.imm_val  <= '0;
            sif.issue    <= 1'b0;
            sif.busy     <= 1'b0;
            sif.done     <= 1'b0;
        end else begin
            // NOP is the default drive; only an advancing RUN cycle overrides it
            sif.opcode   <= NOP_OP;
            sif.mem_addr <= '0;
            sif.imm_val  <= '0;
            sif.issue    <= 1'b0;
            sif.busy     <= 1'b0;
            sif.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sif.start && !sif.abort) begin
                        state  <= S_RUN;
                        pc     <= '0;
                        pass   <= '0;
                        last_q <= sif.prog_last;
                        rep_q  <= sif.rep_cnt;
                    end
                end
                S_RUN: begin
                    if (sif.abort) begin
                        state <= S_IDLE;
                    end else if (advance) begin
                        sif.opcode   <= cur.opcode;
                        sif.mem_addr <= cur.mem_addr;
                        sif.imm_val  <= cur.imm_val;
                        sif.issue    <= 1'b1;
                        sif.busy     <= 1'b1;
                        if (pc == last_q) begin
                            pc <= '0;
                            if (pass == rep_q) state <= S_DONE;
                            else               pass  <= pass + 4'd1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end else begin
                        // Stalled step cycle: still running, nothing issued
                        sif.busy <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    sif.done <= !sif.abort;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: vector table plus directed multi-cycle runs.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_instr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_seq_if #(.AW(4)) sif ();

    instr_seq #(.DEPTH(16), .AW(4), .NOP_OP(3'b000)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic        we;
        logic [3:0]  waddr;
        logic [10:0] wdata;
        logic [3:0]  last;
        logic [3:0]  rep;
        logic [10:0] ew;
        logic        ei;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t        vt [22];
    logic [10:0] w  [16];

    function automatic vec_t mk(input logic st, input logic ab, input logic we,
                                input logic [3:0] wa, input logic [10:0] wd,
                                input logic [3:0] la, input logic [3:0] rp,
                                input logic [10:0] ew, input logic ei,
                                input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.abort = ab; v.we = we; v.waddr = wa; v.wdata = wd;
        v.last = la; v.rep = rp; v.ew = ew; v.ei = ei; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {sif.opcode, sif.mem_addr, sif.imm_val, sif.issue, sif.busy, sif.done};
    endfunction

    task automatic check(input string nm, input logic [10:0] ew, input logic ei,
                         input logic eb, input logic ed);
        logic [13:0] got;
        logic [13:0] exp;
        got = outs();
        exp = {ew, ei, eb, ed};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got word=%h issue/busy/done=%b, required word=%h issue/busy/done=%b",
                     nm, got[13:3], got[2:0], exp[13:3], exp[2:0]);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [10:0] d);
        sif.prog_we   = 1'b1;
        sif.prog_addr = a;
        sif.prog_data = d;
        step_clk();
        sif.prog_we   = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] la, input logic [3:0] rp);
        sif.prog_last = la;
        sif.rep_cnt   = rp;
        sif.start     = 1'b1;
        step_clk();
        sif.start     = 1'b0;
    endtask

    initial begin
        sif.prog_we = 1'b0; sif.prog_addr = '0; sif.prog_data = '0;
        sif.prog_last = '0; sif.rep_cnt = '0; sif.start = 1'b0; sif.abort = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
        sif.step_mode = 1'b0; sif.step = 1'b0;
`endif

        // Single pass, then abort with ignored start/prog_we, rerun, priority and DONE abort
        vt[0]  = mk(1,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[1]  = mk(0,0,0,0,0,      2,0, 11'h1A5,1,1,0);
        vt[2]  = mk(0,0,0,0,0,      2,0, 11'h2B6,1,1,0);
        vt[3]  = mk(0,0,0,0,0,      2,0, 11'h3C7,1,1,0);
        vt[4]  = mk(0,0,0,0,0,      2,0, 11'h000,0,0,1);
        vt[5]  = mk(0,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[6]  = mk(1,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[7]  = mk(1,0,1,0,11'h7FF,2,0, 11'h1A5,1,1,0);
        vt[8]  = mk(0,0,1,1,11'h7FF,2,0, 11'h2B6,1,1,0);
        vt[9]  = mk(0,1,0,0,0,      2,0, 11'h000,0,0,0);
        vt[10] = mk(0,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[11] = mk(1,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[12] = mk(0,0,0,0,0,      2,0, 11'h1A5,1,1,0);
        vt[13] = mk(0,0,0,0,0,      2,0, 11'h2B6,1,1,0);
        vt[14] = mk(0,0,0,0,0,      2,0, 11'h3C7,1,1,0);
        vt[15] = mk(0,0,0,0,0,      2,0, 11'h000,0,0,1);
        vt[16] = mk(1,1,0,0,0,      2,0, 11'h000,0,0,0);
        vt[17] = mk(0,0,0,0,0,      2,0, 11'h000,0,0,0);
        vt[18] = mk(1,0,0,0,0,      0,0, 11'h000,0,0,0);
        vt[19] = mk(0,0,0,0,0,      0,0, 11'h1A5,1,1,0);
        vt[20] = mk(0,1,0,0,0,      0,0, 11'h000,0,0,0);
        vt[21] = mk(0,0,0,0,0,      0,0, 11'h000,0,0,0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] i4;
            i4 = 4'(i);
            w[i] = {i4[2:0], i4, ~i4};
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 11'h000, 0, 0, 0);
        rst = 1'b0;
        step_clk();
        check("idle_after_reset", 11'h000, 0, 0, 0);

        write_word(4'd0, 11'h1A5);
        write_word(4'd1, 11'h2B6);
        write_word(4'd2, 11'h3C7);

        for (int i = 0; i < 22; i++) begin
            sif.start     = vt[i].start;
            sif.abort     = vt[i].abort;
            sif.prog_we   = vt[i].we;
            sif.prog_addr = vt[i].waddr;
            sif.prog_data = vt[i].wdata;
            sif.prog_last = vt[i].last;
            sif.rep_cnt   = vt[i].rep;
            step_clk();
            check($sformatf("vec%0d", i), vt[i].ew, vt[i].ei, vt[i].eb, vt[i].ed);
        end
        sif.start = 1'b0; sif.abort = 1'b0; sif.prog_we = 1'b0;

        // Repeat run: 3 words x 3 passes, one done pulse
        begin
            logic [10:0] prog3 [3];
            int n_done;
            prog3[0] = 11'h1A5; prog3[1] = 11'h2B6; prog3[2] = 11'h3C7;
            start_run(4'd2, 4'd2);
            check("rep_first_cycle_nop", 11'h000, 0, 0, 0);
            for (int k = 0; k < 9; k++) begin
                step_clk();
                check($sformatf("rep_issue%0d", k), prog3[k % 3], 1, 1, 0);
            end
            n_done = 0;
            for (int k = 0; k < 4; k++) begin
                step_clk();
                if (sif.done === 1'b1) n_done++;
                if (k == 0) check("rep_done", 11'h000, 0, 0, 1);
            end
            n_cmp++;
            if (n_done != 1) begin
                n_err++;
                $display("FAIL rep_done_count: got %0d pulses, required 1", n_done);
            end
        end

        // Asynchronous reset mid-run
        start_run(4'd2, 4'd2);
        step_clk();
        step_clk();
        check("pre_reset_issue", 11'h2B6, 1, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_nop", 11'h000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_clk();
        check("post_reset_idle", 11'h000, 0, 0, 0);
        start_run(4'd2, 4'd0);
        step_clk();
        check("post_reset_pc0", 11'h1A5, 1, 1, 0);
        sif.abort = 1'b1;
        step_clk();
        sif.abort = 1'b0;
        check("post_reset_abort", 11'h000, 0, 0, 0);
        step_clk();

`ifdef INSTR_SEQ_STEP_EN
        // Step mode: one issue per step pulse, busy held between
        begin
            logic [10:0] prog3 [3];
            int n_iss;
            prog3[0] = 11'h1A5; prog3[1] = 11'h2B6; prog3[2] = 11'h3C7;
            sif.step_mode = 1'b1;
            start_run(4'd2, 4'd0);
            n_iss = 0;
            for (int k = 0; k < 9; k++) begin
                sif.step = (k % 3 == 2);
                step_clk();
                if (k % 3 == 2) begin
                    check($sformatf("step_issue%0d", k), prog3[n_iss], 1, 1, 0);
                    n_iss++;
                end else begin
                    check($sformatf("step_hold%0d", k), 11'h000, 0, 1, 0);
                end
            end
            sif.step = 1'b0;
            step_clk();
            check("step_done", 11'h000, 0, 0, 1);
            sif.step_mode = 1'b0;
            step_clk();
        end
`endif

        // Boundary: full 16-word program, 16 passes
        for (int i = 0; i < 16; i++) write_word(4'(i), w[i]);
        start_run(4'd15, 4'd15);
        check("full_start", 11'h000, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            step_clk();
            check($sformatf("full_issue%0d", k), w[k % 16], 1, 1, 0);
        end
        step_clk();
        check("full_done", 11'h000, 0, 0, 1);
        step_clk();
        check("full_idle", 11'h000, 0, 0, 0);

        // Single-word program written the cycle before start, repeated 4 times
        write_word(4'd0, 11'h5E1);
        start_run(4'd0, 4'd3);
        for (int k = 0; k < 4; k++) begin
            step_clk();
            check($sformatf("single_issue%0d", k), 11'h5E1, 1, 1, 0);
        end
        step_clk();
        check("single_done", 11'h000, 0, 0, 1);
        step_clk();
        check("single_idle", 11'h000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
